isp_pixel_stream_tx: RTL and testbench

//  Raster transmitter that produces the pixel/enable stream (data + dataEn) consumed by the ISP

---
 rtl/isp_pkg.sv | 18 +
 rtl/isp_sync_fifo.sv | 59 +++++
 rtl/isp_pixel_stream_tx.sv | 136 +++++++++++++
 tb/tb_isp_pixel_stream_tx.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isp_pkg.sv
// Shared types and default raster constants for the ISP pixel-stream transmitter.
package isp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    localparam int unsigned DEF_DW       = 16;
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_BLANK  = 160;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_BLANK  = 45;
    localparam int unsigned DEF_FIFO_AW  = 3;

endpackage

// File: rtl/isp_sync_fifo.sv
// Count-based single-clock FIFO with registered read data (one cycle read latency).
module isp_sync_fifo #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] wr_data,
    input  logic          pop,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int unsigned DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            rd_data <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Storage is not reset; pointer reset alone discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/isp_pixel_stream_tx.sv
// Fixed-timing raster transmitter: prefetch FIFO feeding active/H-blank/V-blank pixel stream.
module isp_pixel_stream_tx
    import isp_pkg::*;
#(
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_BLANK  = DEF_H_BLANK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_BLANK  = DEF_V_BLANK,
    parameter int unsigned FIFO_AW  = DEF_FIFO_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] px_data,
    output logic          px_en,
    output logic          line_start,
    output logic          frame_start,
    output logic          underflow,
    output logic          busy
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0]    H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0]    H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]    V_ACT_LAST = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0]    V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [FIFO_AW:0] PREFETCH   = (FIFO_AW+1)'(2 ** (FIFO_AW - 1));

    state_t         state;
    logic [HW-1:0]  h_cnt;
    logic [VW-1:0]  v_cnt;
    logic           ready_q;
    logic           data_sel;

    logic           push;
    logic           pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [FIFO_AW:0] fifo_level;
    logic [DW-1:0]  fifo_rd_data;

    logic           at_origin;

    assign s_ready   = ready_q && !fifo_full;
    assign push      = s_valid && s_ready;
    assign pop       = (state == ST_ACTIVE) && !fifo_empty;
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign busy      = (state != ST_IDLE);

    // FIFO read data lands one cycle after the pop, aligned with the registered px_en.
    assign px_data   = data_sel ? fifo_rd_data : '0;

    isp_sync_fifo #(
        .DW (DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (s_data),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            h_cnt       <= '0;
            v_cnt       <= '0;
            ready_q     <= 1'b0;
            data_sel    <= 1'b0;
            px_en       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            data_sel    <= pop;
            px_en       <= (state == ST_ACTIVE);
            line_start  <= (state == ST_ACTIVE) && (h_cnt == '0);
            frame_start <= (state == ST_ACTIVE) && at_origin;

            // Starvation at the first pixel re-arms underflow even though the frame restarts.
            if ((state == ST_ACTIVE) && fifo_empty) begin
                underflow <= 1'b1;
            end else if ((state == ST_ACTIVE) && at_origin) begin
                underflow <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (enable && (fifo_level >= PREFETCH)) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (h_cnt == H_ACT_LAST) begin
                        state <= ST_HBLANK;
                    end
                end
                ST_HBLANK: begin
                    if (h_cnt == H_LAST) begin
                        state <= (v_cnt == V_ACT_LAST) ? ST_VBLANK : ST_ACTIVE;
                    end
                end
                ST_VBLANK: begin
                    if ((h_cnt == H_LAST) && (v_cnt == V_LAST)) begin
                        state <= enable ? ST_ACTIVE : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (state != ST_IDLE) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
                end else begin
                    h_cnt <= h_cnt + HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_isp_pixel_stream_tx.sv
// Directed self-checking bench for isp_pixel_stream_tx with a 4x3 active / 6x5 total raster.
module tb_isp_pixel_stream_tx;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] px_data;
    logic        px_en;
    logic        line_start;
    logic        frame_start;
    logic        underflow;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int src_next = 1;
    int src_left = 0;

    isp_pixel_stream_tx #(
        .DW       (16),
        .H_ACTIVE (4),
        .H_BLANK  (2),
        .V_ACTIVE (3),
        .V_BLANK  (2),
        .FIFO_AW  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .px_data     (px_data),
        .px_en       (px_en),
        .line_start  (line_start),
        .frame_start (frame_start),
        .underflow   (underflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Position k after frame_start: active when inside the 4 active columns of the 3 active lines.
    function automatic bit act(input int k);
        return ((k % 30) / 6 < 3) && ((k % 30) % 6 < 4);
    endfunction

    function automatic int pidx(input int k);
        return ((k % 30) / 6) * 4 + (k % 30) % 6;
    endfunction

    // Called at a negedge; advances one clock and returns at the next negedge.
    task automatic tick();
        logic acc;
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (acc) begin
            src_next++;
            src_left--;
        end
        s_data  = 16'(src_next);
        s_valid = (src_left > 0);
        @(negedge clk);
    endtask

    task automatic set_src(input int n);
        src_left = n;
        s_data   = 16'(src_next);
        s_valid  = (n > 0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        enable   = 1'b0;
        src_next = 1;
        src_left = 0;
        s_data   = 16'd1;
        s_valid  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, px_en, line_start, frame_start, underflow, busy, px_data} !== 22'h0)
            $display("FAIL reset_outputs got=%h exp=%h",
                     {s_ready, px_en, line_start, frame_start, underflow, busy, px_data}, 22'h0);
        else passes++;
        do_reset();
        tick();
        checks++;
        if ({s_ready, px_en, busy} !== 3'b100)
            $display("FAIL post_reset_ready got=%b exp=%b", {s_ready, px_en, busy}, 3'b100);
        else passes++;
    endtask

    task automatic test_continuous();
        logic [20:0] got, exp;
        int n;
        bit a;
        do_reset();
        enable = 1'b1;
        set_src(1000);
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) $display("FAIL cont_frame_start timeout got=0 exp=1"); else passes++;
        for (int k = 0; k < 60; k++) begin
            a   = act(k);
            got = {px_en, line_start, frame_start, underflow, busy, px_data};
            exp = {a, a && (k % 6 == 0), (k % 30) == 0, 1'b0, 1'b1,
                   a ? 16'((k / 30) * 12 + pidx(k) + 1) : 16'h0};
            checks++;
            if (got !== exp) $display("FAIL cont_raster k=%0d got=%h exp=%h", k, got, exp);
            else passes++;
            tick();
        end
    endtask

    task automatic test_prefetch();
        int n;
        do_reset();
        enable = 1'b1;
        set_src(3);
        for (n = 0; n < 10; n++) tick();
        checks++;
        if ({busy, px_en} !== 2'b00)
            $display("FAIL prefetch_idle got=%b exp=%b", {busy, px_en}, 2'b00);
        else passes++;
        set_src(1);
        tick();
        checks++;
        if (busy !== 1'b0) $display("FAIL prefetch_fourth_push got=%b exp=0", busy); else passes++;
        tick();
        checks++;
        if (busy !== 1'b1) $display("FAIL prefetch_start got=%b exp=1", busy); else passes++;
        tick();
        checks++;
        if ({frame_start, px_en, px_data} !== {2'b11, 16'h0001})
            $display("FAIL prefetch_first_px got=%h exp=%h", {frame_start, px_en, px_data},
                     {2'b11, 16'h0001});
        else passes++;
    endtask

    task automatic test_underflow();
        logic [20:0] got, exp;
        int n;
        bit a;
        do_reset();
        enable = 1'b1;
        set_src(6);
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) $display("FAIL uf_frame_start timeout got=0 exp=1"); else passes++;
        for (int k = 0; k < 30; k++) begin
            a   = act(k);
            got = {px_en, line_start, frame_start, underflow, busy, px_data};
            exp = {a, a && (k % 6 == 0), k == 0, k >= 8, 1'b1,
                   (a && pidx(k) < 6) ? 16'(pidx(k) + 1) : 16'h0};
            checks++;
            if (got !== exp) $display("FAIL uf_raster k=%0d got=%h exp=%h", k, got, exp);
            else passes++;
            if (k == 20) set_src(8);
            tick();
        end
        checks++;
        if ({frame_start, px_en, underflow, px_data} !== {3'b110, 16'h0007})
            $display("FAIL uf_clear got=%h exp=%h", {frame_start, px_en, underflow, px_data},
                     {3'b110, 16'h0007});
        else passes++;
    endtask

    task automatic test_stop();
        logic [20:0] got, exp;
        int n;
        bit a;
        do_reset();
        enable = 1'b1;
        set_src(1000);
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) $display("FAIL stop_frame_start timeout got=0 exp=1"); else passes++;
        for (int k = 0; k < 30; k++) begin
            a   = act(k);
            got = {px_en, line_start, frame_start, underflow, busy, px_data};
            exp = {a, a && (k % 6 == 0), k == 0, 1'b0, k < 29,
                   a ? 16'(pidx(k) + 1) : 16'h0};
            checks++;
            if (got !== exp) $display("FAIL stop_raster k=%0d got=%h exp=%h", k, got, exp);
            else passes++;
            if (k == 7) enable = 1'b0;
            tick();
        end
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (px_en !== 1'b0 || busy !== 1'b0) n++;
            tick();
        end
        checks++;
        if (n != 0) $display("FAIL stop_idle active_cycles got=%0d exp=0", n); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [20:0] got, exp;
        int n;
        bit a;
        do_reset();
        enable = 1'b1;
        set_src(12);
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) $display("FAIL b2b_frame_start timeout got=0 exp=1"); else passes++;
        for (int k = 0; k < 60; k++) begin
            a   = act(k);
            got = {px_en, line_start, frame_start, underflow, busy, px_data};
            exp = {a, a && (k % 6 == 0), (k % 30) == 0, 1'b0, 1'b1,
                   a ? 16'((k / 30) * 12 + pidx(k) + 1) : 16'h0};
            checks++;
            if (got !== exp) $display("FAIL b2b_raster k=%0d got=%h exp=%h", k, got, exp);
            else passes++;
            if (k >= 18 && k < 30) begin
                checks++;
                if (s_ready !== (k < 26))
                    $display("FAIL b2b_s_ready k=%0d got=%b exp=%b", k, s_ready, k < 26);
                else passes++;
            end
            if (k == 18) set_src(20);
            tick();
        end
    endtask

    task automatic test_reset_mid_frame();
        int n;
        do_reset();
        enable = 1'b1;
        set_src(1000);
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) $display("FAIL rst_frame_start timeout got=0 exp=1"); else passes++;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({s_ready, px_en, line_start, frame_start, underflow, busy, px_data} !== 22'h0)
            $display("FAIL rst_mid_outputs got=%h exp=%h",
                     {s_ready, px_en, line_start, frame_start, underflow, busy, px_data}, 22'h0);
        else passes++;
        @(negedge clk);
        do_reset();
        enable = 1'b1;
        set_src(1000);
        n = 0;
        while (frame_start !== 1'b1 && n < 200) begin tick(); n++; end
        checks++;
        if (n >= 200) $display("FAIL rst_restart timeout got=0 exp=1"); else passes++;
        checks++;
        if ({px_en, line_start, underflow, px_data} !== {3'b110, 16'h0001})
            $display("FAIL rst_restart_px got=%h exp=%h", {px_en, line_start, underflow, px_data},
                     {3'b110, 16'h0001});
        else passes++;
    endtask

    initial begin
        rst_n   = 1'b0;
        enable  = 1'b0;
        s_data  = 16'd0;
        s_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_continuous();
        test_prefetch();
        test_underflow();
        test_stop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
